rca_61bit_settle_ctrl: RTL
==========================

// Module: rca_61bit_settle_ctrl
// PURPOSE
//   Upstream/downstream sequencer for the combinational ripple_carry_adder_61bit.
//   Accepts operand pairs on a valid/ready handshake and drives them onto the adder.
//   Holds them stable for SETTLE_CYCLES clocks so the ripple carry chain resolves.
//   Captures the adder result into a register and presents it on a valid/ready output.
// PARAMETERS
//   WIDTH          61   operand width; the adder result is WIDTH+1 bits
//   SETTLE_CYCLES  4    clocks from operand launch to result capture; legal range >= 1
//   CNT_W          16   width of the carry-out (overflow) event counter
// PORTS
//   i_clk           in   1        single clock, rising edge
//   i_rst           in   1        asynchronous, active-high reset
//   i_in_valid      in   1        operand pair valid
//   o_in_ready      out  1        ready to accept an operand pair
//   i_a             in   WIDTH    operand A
//   i_b             in   WIDTH    operand B
//   o_add_term1     out  WIDTH    registered A, drives adder i_add_term1
//   o_add_term2     out  WIDTH    registered B, drives adder i_add_term2
//   i_adder_result  in   WIDTH+1  adder o_result; bit WIDTH is carry-out
//   o_out_valid     out  1        o_sum valid
//   i_out_ready     in   1        consumer ready
//   o_sum           out  WIDTH+1  captured result
//   o_busy          out  1        high in SETTLE or DONE
//   i_clr_ovf       in   1        synchronous clear of o_ovf_count
//   o_ovf_count     out  CNT_W    saturating count of captures with carry-out = 1
// BEHAVIOUR
//   Reset (async, i_rst=1):
//   - state=IDLE; o_add_term1/2, o_sum, o_ovf_count, o_out_valid all 0
//   - o_in_ready is forced 0 while i_rst=1
//   FSM, IDLE: o_in_ready=1.
//   - On i_in_valid & o_in_ready: latch i_a/i_b into o_add_term1/2.
//   - Load settle counter with SETTLE_CYCLES-1, then go to SETTLE.
//   FSM, SETTLE: o_in_ready=0.
//   - Counter decrements each clock.
//   - On the edge where the counter = 0: o_sum <= i_adder_result, o_out_valid <= 1, go to DONE.
//   FSM, DONE: o_in_ready=0; o_sum and o_out_valid held.
//   - On o_out_valid & i_out_ready: o_out_valid <= 0, go to IDLE.
//   Latency and throughput:
//   - Accept at edge k, capture at edge k+SETTLE_CYCLES.
//   - o_out_valid is high from edge k+SETTLE_CYCLES.
//   - Best case is one operation per SETTLE_CYCLES+2 clocks.
//   Operand and result hold rules:
//   - o_add_term1/2 change only on an input handshake.
//   - They are held through SETTLE and DONE, and are not cleared on return to IDLE.
//   - o_sum changes only at capture; it is held after output handshake until the next capture.
//   Backpressure: DONE waits indefinitely; i_in_valid is ignored outside IDLE and no operand is latched.
//   SETTLE_CYCLES=1: capture on the first edge after accept.
//   Overflow counter:
//   - At capture, if i_adder_result[WIDTH]=1, o_ovf_count increments.
//   - It saturates at all-ones and does not wrap.
//   - i_clr_ovf=1 sets the count to 0; clear wins over a same-cycle increment.
//   Reset mid-operation: the in-flight operation is abandoned, no o_out_valid pulse, state returns to IDLE.
//   o_busy = (state != IDLE).
// TESTING (bench instantiates ripple_carry_adder_61bit in the loop)
//   1 Assert i_rst mid-cycle -> all outputs 0 immediately, o_in_ready=0; release -> o_in_ready=1, o_busy=0.
//   2 A=1, B=2, SETTLE_CYCLES=4, i_out_ready=1 -> o_out_valid rises 4 edges after accept, o_sum=3, o_ovf_count=0.
//   3 A=2^61-1, B=1 -> o_sum=62'h2000_0000_0000_0000, o_ovf_count=1.
//   4 Hold i_out_ready=0 for 10 clocks with i_in_valid=1 -> o_sum/o_out_valid stable, o_in_ready=0, o_add_term1/2 unchanged.
//   5 Assert i_rst during SETTLE (2nd cycle) -> no o_out_valid; after release a new add A=5, B=7 returns o_sum=12.
//   6 CNT_W=2, five overflowing adds -> o_ovf_count=3 (saturated).
//     Then i_clr_ovf coincident with an overflowing capture -> o_ovf_count=0.

Source files
------------

// File: rtl/rca_61bit_settle_ctrl.sv
// rtl/rca_61bit_settle_ctrl.sv - valid/ready sequencer that launches operands onto a
// combinational ripple-carry adder, waits for the carry chain to settle, then captures the sum.
module rca_61bit_settle_ctrl #(
  parameter int WIDTH         = 61,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_add_term1,
  output logic [WIDTH-1:0] o_add_term2,
  input  logic [WIDTH:0]   i_adder_result,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH:0]   o_sum,
  output logic             o_busy,
  input  logic             i_clr_ovf,
  output logic [CNT_W-1:0] o_ovf_count
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  state_t          state;
  logic [SC_W-1:0] settle_cnt;
  logic            capture;

  assign capture    = (state == SETTLE) && (settle_cnt == '0);
  // Ready is gated by reset so no operand can be offered while the block is held.
  assign o_in_ready = (state == IDLE) && !i_rst;
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      o_add_term1 <= '0;
      o_add_term2 <= '0;
      o_sum       <= '0;
      o_out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_in_valid && o_in_ready) begin
            o_add_term1 <= i_a;
            o_add_term2 <= i_b;
            settle_cnt  <= SETTLE_LOAD;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            o_sum       <= i_adder_result;
            o_out_valid <= 1'b1;
            state       <= DONE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        DONE: begin
          if (o_out_valid && i_out_ready) begin
            o_out_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating carry-out counter; a clear beats an increment in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf_count <= '0;
    end else if (i_clr_ovf) begin
      o_ovf_count <= '0;
    end else if (capture && i_adder_result[WIDTH] && (o_ovf_count != '1)) begin
      o_ovf_count <= o_ovf_count + 1'b1;
    end
  end

endmodule
